// File: rtl/gmii_demux.sv
`timescale 1ns/1ps
// gmii_demux: routes tagged GMII frames from a single byte stream to one of
// NUM_OUTPUTS handshaked outputs. Each output has its own store-and-forward
// FIFO, so a frame only becomes readable once its last byte has been written.
// Frames that overflow their FIFO, or that carry an out-of-range tag, are
// dropped whole.
module gmii_demux #(
   parameter int unsigned NUM_OUTPUTS = 2,
   parameter int unsigned FIFO_DEPTH  = 64
)(
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [7:0]                    Input_data,
   input  logic                          Input_valid,
   input  logic                          Input_last,
   output logic [NUM_OUTPUTS-1:0][7:0]   Output_data,
   output logic [NUM_OUTPUTS-1:0]        Output_valid,
   output logic [NUM_OUTPUTS-1:0]        Output_last,
   input  logic [NUM_OUTPUTS-1:0]        Output_ready,
   output logic [NUM_OUTPUTS-1:0]        Frame_dropped,
   output logic                          Bad_tag
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned SW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] PTR_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_DISCARD
   } state_t;

   state_t state, state_nxt;

   logic [SW-1:0] sel_q, sel_nxt;
   logic [SW-1:0] tag_sel;
   logic [SW-1:0] cur_sel;
   logic          tag_bad;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr     [NUM_OUTPUTS];
   logic [AW:0] commit_ptr [NUM_OUTPUTS];
   logic [AW:0] rd_ptr     [NUM_OUTPUTS];
   logic [8:0]  mem        [NUM_OUTPUTS][FIFO_DEPTH];

   logic [NUM_OUTPUTS-1:0] full;
   logic [NUM_OUTPUTS-1:0] rd_fire;

   logic wr_en;
   logic commit;
   logic rewind;
   logic drop;
   logic bad;

   assign tag_bad = (32'(Input_data) >= NUM_OUTPUTS);
   assign tag_sel = Input_data[SW-1:0];
   // The tag byte is routed directly; later bytes use the latched selection.
   assign cur_sel = (state == S_IDLE) ? tag_sel : sel_q;

   // FIFO full flags, using the registered read pointer of this cycle.
   always_comb begin
      full = '0;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
         full[i] = ((wr_ptr[i] - rd_ptr[i]) == PTR_FULL);
      end
   end

   // First-word-fall-through read side: only committed bytes are visible.
   always_comb begin
      Output_valid = '0;
      Output_data  = '0;
      Output_last  = '0;
      rd_fire      = '0;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
         Output_valid[i] = (commit_ptr[i] != rd_ptr[i]);
         Output_data[i]  = mem[i][rd_ptr[i][AW-1:0]][7:0];
         Output_last[i]  = mem[i][rd_ptr[i][AW-1:0]][8];
         rd_fire[i]      = (commit_ptr[i] != rd_ptr[i]) && Output_ready[i];
      end
   end

   // Input FSM state and selected-output register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_IDLE;
         sel_q <= '0;
      end else begin
         state <= state_nxt;
         sel_q <= sel_nxt;
      end
   end

   // Input FSM next state plus write/commit/rewind/drop decisions.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      wr_en     = 1'b0;
      commit    = 1'b0;
      rewind    = 1'b0;
      drop      = 1'b0;
      bad       = 1'b0;
      case (state)
         S_IDLE: begin
            if (Input_valid) begin
               if (tag_bad) begin
                  bad = 1'b1;
                  if (!Input_last) state_nxt = S_DISCARD;
               end else begin
                  sel_nxt = tag_sel;
                  if (full[tag_sel]) begin
                     drop = 1'b1;
                     if (!Input_last) state_nxt = S_DISCARD;
                  end else begin
                     wr_en = 1'b1;
                     if (Input_last) commit = 1'b1;
                     else            state_nxt = S_ACCEPT;
                  end
               end
            end
         end
         S_ACCEPT: begin
            if (Input_valid) begin
               if (!full[sel_q]) begin
                  wr_en = 1'b1;
                  if (Input_last) begin
                     commit    = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end else begin
                  // Out of room mid-frame: discard everything written so far.
                  rewind    = 1'b1;
                  drop      = 1'b1;
                  state_nxt = Input_last ? S_IDLE : S_DISCARD;
               end
            end
         end
         S_DISCARD: begin
            if (Input_valid && Input_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Per-output pointer updates: read advance, write/commit, and rewind.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            wr_ptr[i]     <= '0;
            commit_ptr[i] <= '0;
            rd_ptr[i]     <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            if (rd_fire[i]) rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            if (cur_sel == SW'(i)) begin
               if (wr_en) begin
                  wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                  if (commit) commit_ptr[i] <= wr_ptr[i] + PTR_ONE;
               end else if (rewind) begin
                  wr_ptr[i] <= commit_ptr[i];
               end
            end
         end
      end
   end

   // FIFO storage writes of {last, data}.
   always_ff @(posedge Clk) begin
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
         if (wr_en && (cur_sel == SW'(i))) begin
            mem[i][wr_ptr[i][AW-1:0]] <= {Input_last, Input_data};
         end
      end
   end

   // Registered single-cycle status pulses.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Bad_tag       <= 1'b0;
         Frame_dropped <= '0;
      end else begin
         Bad_tag <= bad;
         for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            Frame_dropped[i] <= drop && (cur_sel == SW'(i));
         end
      end
   end

endmodule

// File: tb/tb_gmii_demux.sv
`timescale 1ns/1ps
// tb_gmii_demux: directed and randomized frames checked against per-output
// queues of expected {last, data} bytes.
module tb_gmii_demux;

   localparam int unsigned N = 2;
   localparam int unsigned D = 64;

   logic               Clk;
   logic               Rst;
   logic [7:0]         Input_data;
   logic               Input_valid;
   logic               Input_last;
   logic [N-1:0][7:0]  Output_data;
   logic [N-1:0]       Output_valid;
   logic [N-1:0]       Output_last;
   logic [N-1:0]       Output_ready;
   logic [N-1:0]       Frame_dropped;
   logic               Bad_tag;

   gmii_demux #(.NUM_OUTPUTS(N), .FIFO_DEPTH(D)) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Input_data    (Input_data),
      .Input_valid   (Input_valid),
      .Input_last    (Input_last),
      .Output_data   (Output_data),
      .Output_valid  (Output_valid),
      .Output_last   (Output_last),
      .Output_ready  (Output_ready),
      .Frame_dropped (Frame_dropped),
      .Bad_tag       (Bad_tag)
   );

   int unsigned pass_cnt = 0;
   int unsigned fail_cnt = 0;
   int unsigned total_cnt = 0;

   logic [8:0]  exp_q [N][$];
   int unsigned rx_frames [N];
   int unsigned drop_cnt [N];
   int unsigned bad_cnt = 0;

   bit           rand_ready = 0;
   logic [N-1:0] fixed_ready = '0;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned pending();
      int unsigned s = 0;
      for (int o = 0; o < N; o++) s += exp_q[o].size();
      return s;
   endfunction

   // Sink ready driver
   initial begin
      Output_ready = '0;
      forever begin
         @(posedge Clk);
         #1;
         Output_ready = rand_ready ? N'($urandom_range(0, (1 << N) - 1)) : fixed_ready;
      end
   end

   // Output monitor: handshakes decided between edges complete at the next posedge
   initial begin
      logic [8:0] e;
      for (int o = 0; o < N; o++) begin
         rx_frames[o] = 0;
         drop_cnt[o]  = 0;
      end
      forever begin
         @(negedge Clk);
         for (int o = 0; o < N; o++) begin
            if (Output_valid[o] === 1'b1 && Output_ready[o] === 1'b1) begin
               if (exp_q[o].size() == 0) begin
                  check($sformatf("out%0d_unexpected", o), 32'(Output_valid[o]), 32'd0);
               end else begin
                  e = exp_q[o].pop_front();
                  check($sformatf("out%0d_byte", o), {23'b0, Output_last[o], Output_data[o]}, 32'(e));
                  if (Output_last[o] === 1'b1) rx_frames[o]++;
               end
            end
            if (Frame_dropped[o] === 1'b1) drop_cnt[o]++;
         end
         if (Bad_tag === 1'b1) bad_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic last);
      Input_valid = 1'b1;
      Input_data  = d;
      Input_last  = last;
      @(posedge Clk);
      #1;
      Input_valid = 1'b0;
      Input_last  = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      Input_valid = 1'b0;
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] tag, input int unsigned len,
                             input bit deliver, input bit gaps);
      logic [7:0] b;
      for (int unsigned i = 0; i < len; i++) begin
         b = (i == 0) ? tag : 8'($urandom);
         if (deliver && (32'(tag) < N)) exp_q[int'(tag)].push_back({(i == len - 1), b});
         send_byte(b, (i == len - 1));
         if (gaps && (i != len - 1) && ($urandom_range(0, 1) == 1)) idle(1);
      end
   endtask

   task automatic drain(input string tag, input int unsigned budget);
      int unsigned n = 0;
      while (pending() != 0 && n < budget) begin
         @(posedge Clk);
         #1;
         n++;
      end
      check(tag, pending(), 32'd0);
   endtask

   initial begin
      int unsigned d0, b0, r0, r1, stored, sent0, sent1;
      logic [7:0] t;
      int unsigned len;
      Rst = 1'b1;
      Input_valid = 1'b0;
      Input_data  = '0;
      Input_last  = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_valid", 32'(Output_valid), 32'd0);
      check("reset_drop", 32'(Frame_dropped), 32'd0);
      check("reset_bad", 32'(Bad_tag), 32'd0);
      Rst = 1'b0;

      // Single frame to output 0 with latency check
      fixed_ready = '1;
      idle(2);
      exp_q[0].push_back({1'b0, 8'h00});
      exp_q[0].push_back({1'b0, 8'h11});
      exp_q[0].push_back({1'b0, 8'h22});
      exp_q[0].push_back({1'b1, 8'h33});
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      Input_valid = 1'b1;
      Input_data  = 8'h33;
      Input_last  = 1'b1;
      #1;
      check("t1_valid_before_last", 32'(Output_valid), 32'd0);
      @(posedge Clk);
      #1;
      Input_valid = 1'b0;
      Input_last  = 1'b0;
      check("t1_valid_rise", 32'(Output_valid), 32'b01);
      idle(8);
      check("t1_drained", exp_q[0].size(), 32'd0);
      check("t1_frames", rx_frames[0], 32'd1);
      check("t1_out1_idle", rx_frames[1], 32'd0);

      // Bad tag frame followed by a normal tag-01 frame
      b0 = bad_cnt;
      r1 = rx_frames[1];
      send_frame(8'h05, 4, 1'b0, 1'b0);
      send_frame(8'h01, 4, 1'b1, 1'b0);
      idle(10);
      check("bad_tag_pulses", bad_cnt - b0, 32'd1);
      check("bad_tag_next_frame", rx_frames[1] - r1, 32'd1);
      check("bad_tag_no_drop", drop_cnt[0] + drop_cnt[1], 32'd0);

      // Single-byte frame
      r1 = rx_frames[1];
      send_frame(8'h01, 1, 1'b1, 1'b0);
      idle(5);
      check("single_byte_frame", rx_frames[1] - r1, 32'd1);
      check("single_byte_drained", pending(), 32'd0);

      // Overflow: output 0 stalled, model stores frames while they fit
      fixed_ready = 2'b10;
      idle(2);
      d0 = drop_cnt[0];
      r0 = rx_frames[0];
      stored = 0;
      for (int f = 0; f < 17; f++) begin
         if (stored + 4 <= D) begin
            stored += 4;
            send_frame(8'h00, 4, 1'b1, 1'b0);
         end else begin
            send_frame(8'h00, 4, 1'b0, 1'b0);
         end
      end
      idle(2);
      check("ovf_drop_pulses", drop_cnt[0] - d0, 32'd1);
      check("ovf_nothing_read", rx_frames[0] - r0, 32'd0);
      fixed_ready = '1;
      drain("ovf_drain", 400);
      idle(4);
      check("ovf_frames_out", rx_frames[0] - r0, 32'd16);
      check("ovf_empty_after", 32'(Output_valid), 32'd0);

      // Randomized interleaved traffic with random sink stalls
      rand_ready = 1;
      d0 = drop_cnt[0] + drop_cnt[1];
      b0 = bad_cnt;
      r0 = rx_frames[0];
      r1 = rx_frames[1];
      sent0 = 0;
      sent1 = 0;
      for (int f = 0; f < 200; f++) begin
         t   = 8'($urandom_range(0, 1));
         len = $urandom_range(1, 11);
         if (t == 8'h00) sent0++;
         else            sent1++;
         send_frame(t, len, 1'b1, 1'b1);
         idle($urandom_range(0, 2));
      end
      drain("rand_drain", 6000);
      rand_ready = 0;
      fixed_ready = '1;
      idle(4);
      check("rand_frames_out0", rx_frames[0] - r0, sent0);
      check("rand_frames_out1", rx_frames[1] - r1, sent1);
      check("rand_no_drop", drop_cnt[0] + drop_cnt[1] - d0, 32'd0);
      check("rand_no_bad", bad_cnt - b0, 32'd0);

      // Reset in the middle of a frame to output 0
      r0 = rx_frames[0];
      send_byte(8'h00, 1'b0);
      send_byte(8'hA1, 1'b0);
      Rst = 1'b1;
      Input_valid = 1'b1;
      Input_data  = 8'hA2;
      @(posedge Clk);
      #1;
      check("midrst_valid", 32'(Output_valid), 32'd0);
      check("midrst_drop", 32'(Frame_dropped), 32'd0);
      check("midrst_bad", 32'(Bad_tag), 32'd0);
      Rst = 1'b0;
      Input_valid = 1'b0;
      idle(5);
      check("midrst_no_output", 32'(Output_valid), 32'd0);
      check("midrst_no_frame", rx_frames[0] - r0, 32'd0);
      send_frame(8'h00, 5, 1'b1, 1'b0);
      idle(10);
      check("midrst_new_frame", rx_frames[0] - r0, 32'd1);
      check("midrst_drained", pending(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
